// File: rtl/gpio_pad_ctrl_if.sv
// Register-access channel between the peripheral bus adapter and gpio_pad_ctrl.
// One request/response slot: request accepted on req_valid&req_ready, reply on resp_valid&resp_ready.
interface gpio_pad_ctrl_if #(
   parameter int NPINS = 8
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [2:0]       req_addr;
   logic [NPINS-1:0] req_wdata;
   logic             resp_valid;
   logic             resp_ready;
   logic [NPINS-1:0] resp_rdata;
   logic             resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad-bank controller: register file driving o/oe/ie, synchronised and
// debounced input returns, edge detection into PENDING and a registered irq.
module gpio_pad_ctrl #(
   parameter int NPINS = 8,
   parameter int DEB_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   gpio_pad_ctrl_if.slave   bus,
   output logic [NPINS-1:0] gpio_o,
   output logic [NPINS-1:0] gpio_oe,
   output logic [NPINS-1:0] gpio_ie,
   input  logic [NPINS-1:0] gpio_i,
   output logic             irq
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

   function automatic logic [DEB_W-1:0] deb_from_wdata(input logic [NPINS-1:0] w);
      logic [NPINS+DEB_W-1:0] ext;
      ext = {{DEB_W{1'b0}}, w};
      return ext[DEB_W-1:0];
   endfunction

   function automatic logic [NPINS-1:0] deb_to_rdata(input logic [DEB_W-1:0] d);
      logic [NPINS+DEB_W-1:0] ext;
      ext = {{NPINS{1'b0}}, d};
      return ext[NPINS-1:0];
   endfunction

   state_e           state_q, state_d;
   logic             ready_q, ready_d, valid_q, valid_d;
   logic [NPINS-1:0] rdata_q, rdata_d;
   logic [NPINS-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d;
   logic [NPINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [NPINS-1:0] pend_q, pend_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [NPINS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
   logic [DEB_W-1:0] cnt_q [NPINS];
   logic [DEB_W-1:0] cnt_d [NPINS];
   logic             irq_q, irq_d;

   logic             acc_s, wr_s, deb_wr_s;
   logic [NPINS-1:0] clr_s, rsel_s, rise_s, fall_s;

   // Register file: read mux on the pre-edge state, writes on an accepted request.
   always_comb begin
      acc_s     = (state_q == ST_IDLE) && bus.req_valid;
      wr_s      = acc_s && bus.req_write;
      out_d     = out_q;
      oe_d      = oe_q;
      ie_d      = ie_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      deb_d     = deb_q;
      deb_wr_s  = 1'b0;
      clr_s     = '0;
      case (bus.req_addr)
         3'd0:    rsel_s = out_q;
         3'd1:    rsel_s = oe_q;
         3'd2:    rsel_s = ie_q;
         3'd3:    rsel_s = filt_q;
         3'd4:    rsel_s = rise_en_q;
         3'd5:    rsel_s = fall_en_q;
         3'd6:    rsel_s = pend_q;
         3'd7:    rsel_s = deb_to_rdata(deb_q);
         default: rsel_s = '0;
      endcase
      if (wr_s) begin
         case (bus.req_addr)
            3'd0:    out_d     = bus.req_wdata;
            3'd1:    oe_d      = bus.req_wdata;
            3'd2:    ie_d      = bus.req_wdata;
            3'd4:    rise_en_d = bus.req_wdata;
            3'd5:    fall_en_d = bus.req_wdata;
            3'd6:    clr_s     = bus.req_wdata;
            3'd7: begin
               deb_d    = deb_from_wdata(bus.req_wdata);
               deb_wr_s = 1'b1;
            end
            default: clr_s     = '0;
         endcase
      end else begin
         deb_wr_s = 1'b0;
      end
   end

   // Request/response handshake with a one-entry response slot.
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = ST_RESP;
               ready_d = 1'b0;
               valid_d = 1'b1;
               rdata_d = bus.req_write ? '0 : rsel_s;
            end else begin
               ready_d = 1'b1;
               valid_d = 1'b0;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               valid_d = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   // Input path: the counter compare covers D=0 and D=1 as immediate acceptance.
   always_comb begin
      sync1_d = gpio_i;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      for (int n = 0; n < NPINS; n++) begin
         cnt_d[n] = cnt_q[n];
         if (deb_wr_s) begin
            cnt_d[n] = '0;
         end else if (sync2_q[n] != filt_q[n]) begin
            if (({1'b0, cnt_q[n]} + {{DEB_W{1'b0}}, 1'b1}) >= {1'b0, deb_q}) begin
               filt_d[n] = sync2_q[n];
               cnt_d[n]  = '0;
            end else begin
               cnt_d[n]  = cnt_q[n] + {{(DEB_W-1){1'b0}}, 1'b1};
            end
         end else begin
            cnt_d[n] = '0;
         end
      end
      rise_s = filt_d & ~filt_q & rise_en_q;
      fall_s = ~filt_d & filt_q & fall_en_q;
      // An event on the same edge as a W1C clear keeps the bit set.
      pend_d = (pend_q & ~clr_s) | rise_s | fall_s;
      irq_d  = |(pend_q & (rise_en_q | fall_en_q));
   end

   // State update with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         rdata_q   <= '0;
         out_q     <= '0;
         oe_q      <= '0;
         ie_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         deb_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         filt_q    <= '0;
         irq_q     <= 1'b0;
         for (int n = 0; n < NPINS; n++) cnt_q[n] <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         rdata_q   <= rdata_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         ie_q      <= ie_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         deb_q     <= deb_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         filt_q    <= filt_d;
         irq_q     <= irq_d;
         for (int n = 0; n < NPINS; n++) cnt_q[n] <= cnt_d[n];
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = 1'b0;
   assign gpio_o         = out_q;
   assign gpio_oe        = oe_q;
   assign gpio_ie        = ie_q;
   assign irq            = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Randomised bench for gpio_pad_ctrl: cycle-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_gpio_pad_ctrl;
   logic       clk;
   logic       rst_n;
   logic [7:0] gpio_o, gpio_oe, gpio_ie, gpio_i, pins;
   logic       irq;
   int         total = 0;
   int         bad = 0;
   bit         chk_en = 0;
   logic [7:0] rd;

   gpio_pad_ctrl_if #(.NPINS(8)) bus ();

   gpio_pad_ctrl #(.NPINS(8), .DEB_W(4)) dut (
      .clock(clk), .reset_n(rst_n), .bus(bus),
      .gpio_o(gpio_o), .gpio_oe(gpio_oe), .gpio_ie(gpio_ie),
      .gpio_i(gpio_i), .irq(irq)
   );

   // The pad cell returns 0 whenever its input buffer is disabled.
   assign gpio_i = pins & gpio_ie;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state.
   logic [7:0] m_out, m_oe, m_ie, m_ren, m_fen, m_pend, m_f, m_s1, m_s2, m_rdata;
   int         m_deb;
   int         m_c[8];
   bit         m_busy, m_valid, m_irq;

   always @(posedge clk) begin : model
      logic [7:0] nf, clr, rsel;
      int         nc[8];
      bit         acc, dwr;
      if (!rst_n) begin
         m_out <= 8'h00; m_oe <= 8'h00; m_ie <= 8'h00; m_ren <= 8'h00; m_fen <= 8'h00;
         m_pend <= 8'h00; m_f <= 8'h00; m_s1 <= 8'h00; m_s2 <= 8'h00; m_rdata <= 8'h00;
         m_deb <= 0; m_busy <= 1'b0; m_valid <= 1'b0; m_irq <= 1'b0;
         for (int n = 0; n < 8; n++) m_c[n] <= 0;
      end else begin
         acc = !m_busy && bus.req_valid;
         dwr = acc && bus.req_write && bus.req_addr == 3'd7;
         clr = (acc && bus.req_write && bus.req_addr == 3'd6) ? bus.req_wdata : 8'h00;
         nf = m_f;
         for (int n = 0; n < 8; n++) begin
            if (dwr) nc[n] = 0;
            else if (m_s2[n] == m_f[n]) nc[n] = 0;
            else if (m_c[n] + 1 >= m_deb) begin nf[n] = m_s2[n]; nc[n] = 0; end
            else nc[n] = m_c[n] + 1;
            m_c[n] <= nc[n];
         end
         m_pend <= (m_pend & ~clr) | (nf & ~m_f & m_ren) | (~nf & m_f & m_fen);
         m_irq  <= (m_pend & (m_ren | m_fen)) != 8'h00;
         m_f    <= nf;
         m_s1   <= gpio_i;
         m_s2   <= m_s1;
         case (bus.req_addr)
            3'd0: rsel = m_out;  3'd1: rsel = m_oe;   3'd2: rsel = m_ie;  3'd3: rsel = m_f;
            3'd4: rsel = m_ren;  3'd5: rsel = m_fen;  3'd6: rsel = m_pend;
            default: rsel = 8'(m_deb);
         endcase
         if (acc) begin
            m_busy  <= 1'b1;
            m_valid <= 1'b1;
            m_rdata <= bus.req_write ? 8'h00 : rsel;
            if (bus.req_write) begin
               case (bus.req_addr)
                  3'd0: m_out <= bus.req_wdata;
                  3'd1: m_oe  <= bus.req_wdata;
                  3'd2: m_ie  <= bus.req_wdata;
                  3'd4: m_ren <= bus.req_wdata;
                  3'd5: m_fen <= bus.req_wdata;
                  3'd7: m_deb <= int'(bus.req_wdata[3:0]);
                  default: ;
               endcase
            end
         end else if (m_busy && bus.resp_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("req_ready", bus.req_ready, !m_busy);
         check("resp_valid", bus.resp_valid, m_valid);
         check("resp_rdata", bus.resp_rdata, m_rdata);
         check("resp_err", bus.resp_err, 0);
         check("gpio_o", gpio_o, m_out);
         check("gpio_oe", gpio_oe, m_oe);
         check("gpio_ie", gpio_ie, m_ie);
         check("irq", irq, m_irq);
      end
   end

   task automatic do_acc(input bit w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] r);
      int t = 0;
      @(negedge clk);
      while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("req_ready_timeout", 0, 1);
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("resp_latency", bus.resp_valid, 1);
      r = bus.resp_rdata;
   endtask

   initial begin
      rst_n = 1'b0; pins = 8'h00;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 3'd0; bus.req_wdata = 8'h00;
      bus.resp_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_en = 1'b1;
         bus.req_valid = 1'($urandom_range(0, 1));
         pins = 8'($urandom);
      end
      @(negedge clk);
      check("rst_ready", bus.req_ready, 1);
      check("rst_valid", bus.resp_valid, 0);
      check("rst_pads", {gpio_o, gpio_oe, gpio_ie}, 0);
      check("rst_irq", irq, 0);
      bus.req_valid = 1'b0; pins = 8'h00; rst_n = 1'b1;
      do_acc(0, 3'd3, 8'h00, rd); check("in_after_reset", rd, 8'h00);

      // Register read/write and pad outputs.
      do_acc(1, 3'd0, 8'hA5, rd); check("gpio_o_A5", gpio_o, 8'hA5); check("wr_rdata0", rd, 8'h00);
      do_acc(1, 3'd1, 8'h0F, rd); check("gpio_oe_0F", gpio_oe, 8'h0F);
      do_acc(1, 3'd2, 8'hFF, rd); check("gpio_ie_FF", gpio_ie, 8'hFF);
      do_acc(0, 3'd0, 8'h00, rd); check("rb_out", rd, 8'hA5);
      do_acc(0, 3'd1, 8'h00, rd); check("rb_oe", rd, 8'h0F);
      do_acc(0, 3'd2, 8'h00, rd); check("rb_ie", rd, 8'hFF);

      // Back-pressure: response held for five cycles.
      @(negedge clk);
      bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         check("bp_ready", bus.req_ready, 0);
         check("bp_rdata", bus.resp_rdata, 8'hA5);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp_idle", bus.req_ready, 1);
      do_acc(0, 3'd1, 8'h00, rd); check("bp_next", rd, 8'h0F);

      // Debounce with D=4: short glitch filtered, long pulse accepted 6 edges later.
      do_acc(1, 3'd2, 8'h01, rd);
      do_acc(1, 3'd7, 8'h04, rd);
      do_acc(0, 3'd7, 8'h00, rd); check("rb_deb", rd, 8'h04);
      do_acc(1, 3'd4, 8'h01, rd);
      @(negedge clk); pins = 8'h01;
      repeat (3) @(negedge clk);
      pins = 8'h00;
      repeat (8) @(negedge clk);
      do_acc(0, 3'd3, 8'h00, rd); check("glitch_in", rd, 8'h00);
      do_acc(0, 3'd6, 8'h00, rd); check("glitch_pend", rd, 8'h00);
      @(negedge clk); pins = 8'h01;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 6) check("deb_irq_k6", irq, 0);
         if (k == 7) check("deb_irq_k7", irq, 1);
      end
      do_acc(0, 3'd3, 8'h00, rd); check("deb_in", rd, 8'h01);
      do_acc(0, 3'd6, 8'h00, rd); check("deb_pend", rd, 8'h01);

      // Interrupt with D=0 and write-1-to-clear.
      do_acc(1, 3'd7, 8'h00, rd);
      do_acc(1, 3'd6, 8'h01, rd); check("w1c_irq_lag", irq, 1);
      @(negedge clk); check("w1c_irq_off", irq, 0);
      pins = 8'h00;
      repeat (5) @(negedge clk);
      @(negedge clk); pins = 8'h01;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 3) check("d0_irq_k3", irq, 0);
         if (k == 4) check("d0_irq_k4", irq, 1);
      end
      do_acc(0, 3'd6, 8'h00, rd); check("d0_pend", rd, 8'h01);
      do_acc(1, 3'd6, 8'h01, rd);
      @(negedge clk); check("d0_clr_irq", irq, 0);
      pins = 8'h00;
      repeat (6) @(negedge clk);
      // Clear lands on the same edge as the rise: set wins.
      @(negedge clk); pins = 8'h01;
      @(negedge clk);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd6; bus.req_wdata = 8'h01;
      @(negedge clk); bus.req_valid = 1'b0;
      do_acc(0, 3'd6, 8'h00, rd); check("set_wins", rd, 8'h01);

      // Randomised traffic, pins and back-pressure; model checks every cycle.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         bus.req_valid  = ($urandom_range(0, 2) == 0);
         bus.req_write  = 1'($urandom_range(0, 1));
         bus.req_addr   = 3'($urandom_range(0, 7));
         bus.req_wdata  = (bus.req_addr == 3'd7) ? 8'($urandom_range(0, 5)) : 8'($urandom);
         for (int n = 0; n < 8; n++)
            if ($urandom_range(0, 7) == 0) pins[n] = ~pins[n];
      end
      @(negedge clk);
      bus.req_valid = 1'b0; bus.resp_ready = 1'b1;

      // Reset while a response is pending and PENDING is full.
      do_acc(1, 3'd7, 8'h00, rd);
      do_acc(1, 3'd2, 8'hFF, rd);
      do_acc(1, 3'd4, 8'hFF, rd);
      do_acc(1, 3'd5, 8'hFF, rd);
      pins = 8'h00;
      repeat (6) @(negedge clk);
      do_acc(1, 3'd6, 8'hFF, rd);
      pins = 8'hFF;
      repeat (6) @(negedge clk);
      do_acc(0, 3'd6, 8'h00, rd); check("pend_full", rd, 8'hFF);
      @(negedge clk);
      bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'd6;
      @(negedge clk); bus.req_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; bus.resp_ready = 1'b1;
      check("mid_rst_valid", bus.resp_valid, 0);
      check("mid_rst_irq", irq, 0);
      check("mid_rst_ready", bus.req_ready, 1);
      do_acc(0, 3'd6, 8'h00, rd); check("mid_rst_pend", rd, 8'h00);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
